ro_freq_counter: RTL and testbench

- Digital readout for the sky130 ring-oscillator macros.
- Takes the raw oscillator output (RO_IN) and divides it down in the RO domain.
- Synchronises the divided signal into CLK and counts its rising edges over a programmable CLK-cycle window.
- Reports the edge count with a DONE pulse, so ring frequency = COUNT * 2^DIV_LOG2 * f_CLK / WINDOW.

---
 rtl/ro_freq_pkg.sv | 25 ++
 rtl/ro_freq_prescaler.sv | 24 ++
 rtl/ro_freq_counter.sv | 165 ++++++++++++++++
 tb/tb_ro_freq_counter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ro_freq_pkg.sv
// Shared state encoding, defaults and ARM-length helper for the ring-oscillator
// frequency counter.
package ro_freq_pkg;

  localparam int DEF_DIV_LOG2    = 4;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_WIN_W       = 16;
  localparam int DEF_SYNC_STAGES = 2;

  // ARM covers the divider release plus a full flush of the synchroniser.
  localparam int ARM_EXTRA   = 2;
  localparam int DEF_ARM_LEN = DEF_SYNC_STAGES + ARM_EXTRA;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic int arm_len(input int sync_stages);
    return sync_stages + ARM_EXTRA;
  endfunction

endpackage

// File: rtl/ro_freq_prescaler.sv
// RO-domain prescaler: the only logic clocked by the ring oscillator. div_clr
// comes from the CLK domain and is held for many RO cycles, so it is used raw.
module ro_freq_prescaler
  import ro_freq_pkg::*;
#(
  parameter int DIV_LOG2 = DEF_DIV_LOG2
) (
  input  logic ro_in,
  input  logic div_clr,
  output logic div_msb
);

  localparam logic [DIV_LOG2-1:0] DIV_ONE = DIV_LOG2'(1);

  logic [DIV_LOG2-1:0] div_q;

  always_ff @(posedge ro_in) begin
    if (div_clr) div_q <= '0;
    else         div_q <= div_q + DIV_ONE;
  end

  assign div_msb = div_q[DIV_LOG2-1];

endmodule

// File: rtl/ro_freq_counter.sv
// Ring-oscillator frequency counter: counts synchronised divided-RO rising edges
// over a WINDOW_CYCLES window. Optional continuous mode under RO_FREQ_CONT_EN.
// Handshake: start is a one-cycle request honoured only in IDLE; done is a
// one-cycle pulse during which count/overflow are valid (held until next done).
module ro_freq_counter
  import ro_freq_pkg::*;
#(
  parameter int DIV_LOG2    = DEF_DIV_LOG2,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int WIN_W       = DEF_WIN_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ro_in,
  input  logic             start,
  input  logic [WIN_W-1:0] window_cycles,
`ifdef RO_FREQ_CONT_EN
  input  logic             cont,
`endif
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output state_t           dbg_state
);

  localparam int                 ARM_LEN  = arm_len(SYNC_STAGES);
  localparam int                 ARM_W    = $clog2(ARM_LEN);
  localparam logic [ARM_W-1:0]   ARM_LAST = ARM_W'(ARM_LEN - 1);
  localparam logic [ARM_W-1:0]   ARM_ONE  = ARM_W'(1);
  localparam logic [WIN_W-1:0]   WIN_ONE  = WIN_W'(1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_MAX  = '1;

  state_t                 state;
  logic                   div_clr;
  logic                   div_msb;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist;
  logic                   rise;
  logic                   cont_i;
  logic [ARM_W-1:0]       arm_cnt;
  logic [WIN_W-1:0]       win_r;
  logic [WIN_W-1:0]       win_cnt;
  logic [CNT_W-1:0]       edge_cnt;
  logic                   ovf_r;
  logic [CNT_W-1:0]       cnt_nxt;
  logic                   ovf_nxt;

  ro_freq_prescaler #(.DIV_LOG2(DIV_LOG2)) u_prescaler (
    .ro_in   (ro_in),
    .div_clr (div_clr),
    .div_msb (div_msb)
  );

`ifdef RO_FREQ_CONT_EN
  assign cont_i = cont;
`else
  assign cont_i = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      hist   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], div_msb};
      hist   <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~hist;

  // Saturating edge counter; lets the final window cycle be reported in done.
  always_comb begin
    cnt_nxt = edge_cnt;
    ovf_nxt = ovf_r;
    if (rise) begin
      if (edge_cnt == CNT_MAX) ovf_nxt = 1'b1;
      else                     cnt_nxt = edge_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      count    <= '0;
      overflow <= 1'b0;
      div_clr  <= 1'b1;
      arm_cnt  <= '0;
      win_r    <= '0;
      win_cnt  <= '0;
      edge_cnt <= '0;
      ovf_r    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            win_r    <= window_cycles;
            edge_cnt <= '0;
            ovf_r    <= 1'b0;
            arm_cnt  <= '0;
            div_clr  <= 1'b0;
            busy     <= 1'b1;
            state    <= ST_ARM;
          end
        end
        ST_ARM: begin
          arm_cnt <= arm_cnt + ARM_ONE;
          if (arm_cnt == ARM_LAST) begin
            win_cnt <= '0;
            if (win_r == '0) begin
              done     <= 1'b1;
              count    <= edge_cnt;
              overflow <= ovf_r;
              busy     <= cont_i;
              state    <= ST_DONE;
            end else begin
              state <= ST_COUNT;
            end
          end
        end
        ST_COUNT: begin
          win_cnt  <= win_cnt + WIN_ONE;
          edge_cnt <= cnt_nxt;
          ovf_r    <= ovf_nxt;
          if (win_cnt == win_r - WIN_ONE) begin
            done     <= 1'b1;
            count    <= cnt_nxt;
            overflow <= ovf_nxt;
            busy     <= cont_i;
            state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (cont_i) begin
            edge_cnt <= '0;
            ovf_r    <= 1'b0;
            win_cnt  <= '0;
            busy     <= 1'b1;
            if (win_r == '0) begin
              done     <= 1'b1;
              count    <= '0;
              overflow <= 1'b0;
            end else begin
              state <= ST_COUNT;
            end
          end else begin
            busy    <= 1'b0;
            div_clr <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_ro_freq_counter.sv
// Self-checking bench for ro_freq_counter: directed steps, expected-result queues
// popped on each done pulse. Exercises continuous mode when RO_FREQ_CONT_EN is set.
module tb_ro_freq_counter;
  import ro_freq_pkg::*;

  localparam int CLK_HALF  = 5;
  localparam int RO_HALF   = 2;
  localparam int CLK_PER   = 2 * CLK_HALF;
  localparam int RO_PER    = 2 * RO_HALF;
  localparam int DIV_LOG2  = 4;
  localparam int SYNC_ST   = 2;
  localparam int ARM_LEN   = SYNC_ST + 2;
  localparam int SAT_CNT_W = 8;

  typedef struct {
    int lo;
    int hi;
    bit ovf;
    int cyc;
  } exp_t;

  // clock / reset
  logic clk   = 1'b0;
  logic ro_in = 1'b0;
  logic rst   = 1'b1;
  int   cyc   = 0;

  always #CLK_HALF clk = ~clk;
  always #RO_HALF ro_in = ~ro_in;
  always @(posedge clk) cyc++;

  // main DUT signals
  logic                 start = 1'b0;
  logic [15:0]          window_cycles = '0;
  logic                 cont = 1'b0;
  logic                 busy, done, overflow;
  logic [15:0]          count;
  state_t               dbg_state;

  // saturation DUT signals
  logic                 start_s = 1'b0;
  logic [15:0]          window_s = '0;
  logic                 busy_s, done_s, overflow_s;
  logic [SAT_CNT_W-1:0] count_s;
  state_t               dbg_state_s;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t sat_q[$];

  ro_freq_counter #(.DIV_LOG2(DIV_LOG2), .CNT_W(16), .WIN_W(16), .SYNC_STAGES(SYNC_ST)) u_dut (
    .clk           (clk),
    .rst           (rst),
    .ro_in         (ro_in),
    .start         (start),
    .window_cycles (window_cycles),
`ifdef RO_FREQ_CONT_EN
    .cont          (cont),
`endif
    .busy          (busy),
    .done          (done),
    .count         (count),
    .overflow      (overflow),
    .dbg_state     (dbg_state)
  );

  ro_freq_counter #(.DIV_LOG2(DIV_LOG2), .CNT_W(SAT_CNT_W), .WIN_W(16), .SYNC_STAGES(SYNC_ST)) u_sat (
    .clk           (clk),
    .rst           (rst),
    .ro_in         (ro_in),
    .start         (start_s),
    .window_cycles (window_s),
`ifdef RO_FREQ_CONT_EN
    .cont          (1'b0),
`endif
    .busy          (busy_s),
    .done          (done_s),
    .count         (count_s),
    .overflow      (overflow_s),
    .dbg_state     (dbg_state_s)
  );

  // Input constraint: divided RO must stay below f_clk/4.
  realtime last_rise  = 0;
  bit      ro_checked = 1'b0;
  always @(posedge ro_in) begin
    if (last_rise > 0 && !ro_checked) begin
      ro_checked = 1'b1;
      checks++;
      assert (($realtime - last_rise) * (1 << DIV_LOG2) > 4.0 * CLK_PER)
        else begin
          errors++;
          $error("FAIL ro_rate: divided period %0t, required above %0d", ($realtime - last_rise) * (1 << DIV_LOG2), 4 * CLK_PER);
        end
    end
    last_rise = $realtime;
  end

  // Expected edge count: divided periods in the window, +-1 for phase.
  function automatic exp_t make_exp(input int w, input int c, input int max_cnt);
    exp_t e;
    int   base;
    base  = (w * CLK_PER) / (RO_PER * (1 << DIV_LOG2));
    e.cyc = c + 1 + ARM_LEN + w;
    if (base - 1 > max_cnt) begin
      e.lo  = max_cnt;
      e.hi  = max_cnt;
      e.ovf = 1'b1;
    end else begin
      e.lo  = (base > 0) ? base - 1 : 0;
      e.hi  = base + 1;
      e.ovf = 1'b0;
    end
    return e;
  endfunction

  task automatic check_result(input string tag, input int c, input logic [15:0] cnt,
                              input logic ovf, input exp_t e);
    bit in_rng;
    checks++;
    assert (c === e.cyc)
      else begin errors++; $error("FAIL %s_latency: done at cycle %0d, expected %0d", tag, c, e.cyc); end
    in_rng = (cnt >= 16'(e.lo)) && (cnt <= 16'(e.hi));
    checks++;
    assert (in_rng === 1'b1)
      else begin errors++; $error("FAIL %s_count: got %0d, expected %0d..%0d", tag, cnt, e.lo, e.hi); end
    checks++;
    assert (ovf === e.ovf)
      else begin errors++; $error("FAIL %s_overflow: got %b, expected %b", tag, ovf, e.ovf); end
  endtask

  // scoreboards
  always @(negedge clk) begin
    if (done === 1'b1) begin
      checks++;
      assert (exp_q.size() > 0)
        else begin errors++; $error("FAIL main_unexpected_done: done at cycle %0d, expected none", cyc); end
      if (exp_q.size() > 0) check_result("main", cyc, count, overflow, exp_q.pop_front());
    end
    if (done_s === 1'b1) begin
      checks++;
      assert (sat_q.size() > 0)
        else begin errors++; $error("FAIL sat_unexpected_done: done at cycle %0d, expected none", cyc); end
      if (sat_q.size() > 0) check_result("sat", cyc, {8'h00, count_s}, overflow_s, sat_q.pop_front());
    end
  end

  // driver tasks (called at a negedge)
  task automatic start_main(input int w, input bit push);
    start         = 1'b1;
    window_cycles = 16'(w);
    if (push) exp_q.push_back(make_exp(w, cyc, 65535));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic start_sat(input int w);
    start_s  = 1'b1;
    window_s = 16'(w);
    sat_q.push_back(make_exp(w, cyc, (1 << SAT_CNT_W) - 1));
    @(negedge clk);
    start_s = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || sat_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    assert (exp_q.size() + sat_q.size() == 0)
      else begin
        errors++;
        $error("FAIL %s_timeout: %0d results outstanding, expected 0", tag, exp_q.size() + sat_q.size());
      end
  endtask

  task automatic check_idle(input string tag);
    checks++;
    assert (busy === 1'b0) else begin errors++; $error("FAIL %s_busy: got %b, expected 0", tag, busy); end
    checks++;
    assert (done === 1'b0) else begin errors++; $error("FAIL %s_done: got %b, expected 0", tag, done); end
    checks++;
    assert (count === 16'h0) else begin errors++; $error("FAIL %s_count: got %0d, expected 0", tag, count); end
    checks++;
    assert (overflow === 1'b0) else begin errors++; $error("FAIL %s_overflow: got %b, expected 0", tag, overflow); end
    checks++;
    assert (dbg_state === ST_IDLE) else begin errors++; $error("FAIL %s_state: got %0d, expected %0d", tag, dbg_state, ST_IDLE); end
  endtask

  initial begin
    int busy_cycles;

    // reset values
    repeat (5) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    @(negedge clk);

    // nominal and boundary windows
    start_main(1000, 1'b1);
    wait_drain(1200, "nominal_1000");
    start_main(300, 1'b1);
    wait_drain(400, "window_300");
    start_main(1, 1'b1);
    wait_drain(50, "window_1");

    // zero window: busy only through ARM
    start_main(0, 1'b1);
    busy_cycles = 0;
    repeat (8) begin
      if (busy === 1'b1) busy_cycles++;
      @(negedge clk);
    end
    checks++;
    assert (busy_cycles === ARM_LEN)
      else begin errors++; $error("FAIL zero_busy_len: got %0d, expected %0d", busy_cycles, ARM_LEN); end
    wait_drain(20, "window_0");

    // ignored start and window change mid-run
    start_main(1000, 1'b1);
    repeat (300) @(negedge clk);
    start_main(50, 1'b0);
    window_cycles = 16'd7;
    wait_drain(1200, "ignored_start");
    repeat (100) @(negedge clk);

    // reset at window cycle ~500
    start_main(1000, 1'b0);
    repeat (ARM_LEN + 500) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle("mid_reset");
    repeat (1100) @(negedge clk);
    start_main(1000, 1'b1);
    wait_drain(1200, "after_reset");

    // saturation on the narrow-counter instance, then a clean short run
    start_sat(2000);
    wait_drain(2200, "saturate");
    start_sat(100);
    wait_drain(200, "post_saturate");

`ifdef RO_FREQ_CONT_EN
    // continuous mode: three windows, one DONE each, then back to IDLE
    begin
      exp_t e0;
      int   n;
      cont = 1'b1;
      e0 = make_exp(1000, cyc, 65535);
      start_main(1000, 1'b0);
      for (int k = 0; k < 3; k++) begin
        exp_t e;
        e     = e0;
        e.cyc = e0.cyc + k * 1001;
        exp_q.push_back(e);
      end
      n = 0;
      while (exp_q.size() > 1 && n < 2500) begin
        @(negedge clk);
        n++;
      end
      @(negedge clk);
      cont = 1'b0;
      wait_drain(1200, "cont");
      repeat (2) @(negedge clk);
      checks++;
      assert (busy === 1'b0)
        else begin errors++; $error("FAIL cont_exit_busy: got %b, expected 0", busy); end
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
